alu_serial: RTL

Parametrised, digit-serial ALU that performs the datapath's arithmetic and logic operations over `WIDTH` bits, processing `DIGIT` bits per clock, LSB digit first. It keeps the established 3-bit operation encoding and adds a start/busy/done handshake, registered results and ARM-style condition flags (N, Z, C, V). It sits between the register-file read ports and the write-back/flag-register stage. Area scales with `DIGIT`, and latency with `WIDTH/DIGIT`.

---
 rtl/alu_serial.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_serial.sv
// Digit-serial ALU: DIGIT bits per clock, LSB digit first, start/busy/done handshake.
// Define ALU_SERIAL_FLAGS_EN to build the N/Z/C/V flag registers; otherwise flags read 0.
module alu_serial #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DIGIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_PASS_B = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_XOR    = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q;

  logic [DIGIT-1:0] a_dig, b_dig, b_eff, dig_d;
  logic [DIGIT:0]   sum_d;
  logic [WIDTH-1:0] acc_d;
  logic             is_arith;

  // One digit of the datapath; the result digit enters the accumulator from the top.
  always_comb begin
    a_dig    = a_q[DIGIT-1:0];
    b_dig    = b_q[DIGIT-1:0];
    is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    b_eff    = (op_q == OP_SUB) ? ~b_dig : b_dig;
    sum_d    = {1'b0, a_dig} + {1'b0, b_eff} + (DIGIT+1)'(carry_q);
    case (op_q)
      OP_PASS_B:      dig_d = b_dig;
      OP_ADD, OP_SUB: dig_d = sum_d[DIGIT-1:0];
      OP_AND:         dig_d = a_dig & b_dig;
      OP_OR:          dig_d = a_dig | b_dig;
      OP_XOR:         dig_d = a_dig ^ b_dig;
      default:        dig_d = '0;
    endcase
    acc_d = (acc_q >> DIGIT) | (WIDTH'(dig_d) << (WIDTH - DIGIT));
  end

`ifdef ALU_SERIAL_FLAGS_EN
  logic neg_q, zero_q, ovf_q, cout_q;
  logic neg_d, zero_d, ovf_d, cout_d;

  // Flags of the full result, evaluated while the last digit is processed.
  always_comb begin
    neg_d  = acc_d[WIDTH-1];
    zero_d = (acc_d == '0);
    cout_d = is_arith & sum_d[DIGIT];
    ovf_d  = is_arith & (a_dig[DIGIT-1] == b_eff[DIGIT-1])
                      & (dig_d[DIGIT-1] != a_dig[DIGIT-1]);
  end

  assign negative  = neg_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign carry_out = cout_q;
`else
  assign negative  = 1'b0;
  assign zero      = 1'b0;
  assign overflow  = 1'b0;
  assign carry_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef ALU_SERIAL_FLAGS_EN
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= (op == OP_SUB);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          acc_q   <= acc_d;
          carry_q <= sum_d[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            result_q <= acc_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            state_q  <= IDLE;
`ifdef ALU_SERIAL_FLAGS_EN
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            cout_q   <= cout_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
